// File: rtl/round_scheduler.sv
// round_scheduler
//   Shares one convergent-rounding (round-half-to-even), saturating requantizer
//   between N_Channels fixed-point producers. A round-robin arbiter grants one
//   channel per cycle into a two-stage pipeline whose second stage drives the
//   Out_* ports under valid/ready with backpressure.
//
// Ports
//   Clk            system clock, rising edge
//   Reset          synchronous active-high reset
//   In_Valid       per-channel request valid
//   In_Ready       per-channel accept, one-hot or zero (combinational)
//   In_Integer     packed two's-complement integer parts, channel k at [k*N_Integer +: N_Integer]
//   In_Fraction    packed unsigned fraction parts, same packing
//   Out_Valid      result valid
//   Out_Ready      downstream accept
//   Out_Data       rounded, saturated result
//   Out_Tag        channel that produced Out_Data
//   Out_Saturated  result was clipped to the maximum positive value
//   Busy           any pipeline stage holds data
module round_scheduler #(
    parameter int unsigned N_Channels = 4,
    parameter int unsigned N_Integer  = 8,
    parameter int unsigned N_Fraction = 8,
    parameter int unsigned N_Tag      = 2
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic [N_Channels-1:0]            In_Valid,
    output logic [N_Channels-1:0]            In_Ready,
    input  logic [N_Channels*N_Integer-1:0]  In_Integer,
    input  logic [N_Channels*N_Fraction-1:0] In_Fraction,
    output logic                             Out_Valid,
    input  logic                             Out_Ready,
    output logic [N_Integer-1:0]             Out_Data,
    output logic [N_Tag-1:0]                 Out_Tag,
    output logic                             Out_Saturated,
    output logic                             Busy
);

    // Round-robin pointer
    logic [N_Tag-1:0]      ptr_q, ptr_d;

    // Stage 1: granted operands
    logic                  s1_valid_q, s1_valid_d;
    logic [N_Integer-1:0]  s1_int_q, s1_int_d;
    logic [N_Fraction-1:0] s1_frac_q, s1_frac_d;
    logic [N_Tag-1:0]      s1_tag_q, s1_tag_d;

    // Stage 2: result registers driving Out_*
    logic                  out_valid_q, out_valid_d;
    logic [N_Integer-1:0]  out_data_q, out_data_d;
    logic [N_Tag-1:0]      out_tag_q, out_tag_d;
    logic                  out_sat_q, out_sat_d;

    logic                  adv1, adv2;
    logic                  grant_found;
    logic [N_Tag-1:0]      grant_idx;
    logic                  grant;

    logic                  round_inc;
    logic [N_Integer:0]    round_sum;
    logic                  round_sat;
    logic [N_Integer-1:0]  round_data;

    assign adv2 = !out_valid_q || Out_Ready;
    assign adv1 = !s1_valid_q || adv2;

    // Search In_Valid from the pointer upward, wrapping modulo N_Channels.
    always_comb begin
        logic [N_Tag:0]   sum_idx;
        logic [N_Tag-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        sum_idx     = '0;
        cand        = '0;
        for (int unsigned i = 0; i < N_Channels; i++) begin
            sum_idx = {1'b0, ptr_q} + (N_Tag+1)'(i);
            if (sum_idx >= (N_Tag+1)'(N_Channels)) begin
                sum_idx = sum_idx - (N_Tag+1)'(N_Channels);
            end
            cand = sum_idx[N_Tag-1:0];
            if (!grant_found && In_Valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Reset gating keeps In_Ready low on the reset cycle so nothing is accepted
    // that the reset edge would then discard.
    assign grant = grant_found && adv1 && !Reset;

    always_comb begin
        In_Ready = '0;
        if (grant) begin
            In_Ready = N_Channels'(1) << grant_idx;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            if (grant_idx == N_Tag'(N_Channels - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + N_Tag'(1);
            end
        end
    end

    // Stage 1 next state
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_int_d   = s1_int_q;
        s1_frac_d  = s1_frac_q;
        s1_tag_d   = s1_tag_q;
        if (adv1) begin
            s1_valid_d = grant;
            if (grant) begin
                s1_int_d  = In_Integer[int'(grant_idx)*N_Integer +: N_Integer];
                s1_frac_d = In_Fraction[int'(grant_idx)*N_Fraction +: N_Fraction];
                s1_tag_d  = grant_idx;
            end
        end
    end

    // Round half to even: increment when the half bit is set and either the
    // value is above the tie (sticky) or the integer is odd.
    always_comb begin
        round_inc  = s1_frac_q[N_Fraction-1] && (s1_int_q[0] || (|s1_frac_q[N_Fraction-2:0]));
        round_sum  = {s1_int_q[N_Integer-1], s1_int_q} + {{N_Integer{1'b0}}, round_inc};
        round_sat  = round_sum[N_Integer] != round_sum[N_Integer-1];
        round_data = round_sat ? {1'b0, {(N_Integer-1){1'b1}}} : round_sum[N_Integer-1:0];
    end

    // Stage 2 next state
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_sat_d   = out_sat_q;
        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = round_data;
                out_tag_d  = s1_tag_q;
                out_sat_d  = round_sat;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_int_q    <= '0;
            s1_frac_q   <= '0;
            s1_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_int_q    <= s1_int_d;
            s1_frac_q   <= s1_frac_d;
            s1_tag_q    <= s1_tag_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_sat_q   <= out_sat_d;
        end
    end

    // Adding at most +1 can only overflow upward; a 10 top-bit pattern means
    // the rounding increment logic is broken.
    always_ff @(posedge Clk) begin
        if (!Reset && s1_valid_q) begin
            assert (!(round_sum[N_Integer] && !round_sum[N_Integer-1]));
        end
    end

    assign Out_Valid     = out_valid_q;
    assign Out_Data      = out_data_q;
    assign Out_Tag       = out_tag_q;
    assign Out_Saturated = out_sat_q;
    assign Busy          = s1_valid_q || out_valid_q;

endmodule

// File: tb/tb_round_scheduler.sv
module tb_round_scheduler;

    localparam int NC = 4;
    localparam int NI = 8;
    localparam int NF = 8;
    localparam int NT = 2;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [NC-1:0]     In_Valid;
    logic [NC-1:0]     In_Ready;
    logic [NC*NI-1:0]  In_Integer;
    logic [NC*NF-1:0]  In_Fraction;
    logic              Out_Valid;
    logic              Out_Ready;
    logic [NI-1:0]     Out_Data;
    logic [NT-1:0]     Out_Tag;
    logic              Out_Saturated;
    logic              Busy;

    int n_vec = 0;
    int n_err = 0;

    round_scheduler #(
        .N_Channels (NC),
        .N_Integer  (NI),
        .N_Fraction (NF),
        .N_Tag      (NT)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .In_Valid      (In_Valid),
        .In_Ready      (In_Ready),
        .In_Integer    (In_Integer),
        .In_Fraction   (In_Fraction),
        .Out_Valid     (Out_Valid),
        .Out_Ready     (Out_Ready),
        .Out_Data      (Out_Data),
        .Out_Tag       (Out_Tag),
        .Out_Saturated (Out_Saturated),
        .Busy          (Busy)
    );

    always #5 Clk = ~Clk;

    // Advance one rising edge; leave 1 time unit after it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [NI-1:0] iv, input logic [NF-1:0] fv);
        In_Integer[k*NI +: NI]  = iv;
        In_Fraction[k*NF +: NF] = fv;
    endtask

    task automatic pulse_reset();
        In_Valid = '0;
        Reset    = 1'b1;
        step();
        Reset    = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        In_Valid    = '0;
        In_Integer  = '0;
        In_Fraction = '0;
        Out_Ready   = 1'b1;
        Reset       = 1'b1;
        step();
        step();
        Reset = 1'b0;
        #1;
        n_vec++; if (Out_Valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", Out_Valid); end
        n_vec++; if (Out_Data !== 8'h00) begin n_err++; $display("FAIL reset_out_data got %h want 00", Out_Data); end
        n_vec++; if (Out_Tag !== 2'd0) begin n_err++; $display("FAIL reset_out_tag got %0d want 0", Out_Tag); end
        n_vec++; if (Out_Saturated !== 1'b0) begin n_err++; $display("FAIL reset_out_sat got %0b want 0", Out_Saturated); end
        n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", Busy); end
        n_vec++; if (In_Ready !== 4'b0000) begin n_err++; $display("FAIL reset_in_ready got %b want 0000", In_Ready); end
    endtask

    task automatic test_rounding();
        logic [7:0] vi [5] = '{8'h02, 8'h03, 8'hFD, 8'h02, 8'h05};
        logic [7:0] vf [5] = '{8'h80, 8'h80, 8'h80, 8'h81, 8'h7F};
        logic [7:0] ve [5] = '{8'h02, 8'h04, 8'hFE, 8'h03, 8'h05};
        Out_Ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            set_ch(0, vi[v], vf[v]);
            In_Valid = 4'b0001;
            #1;
            n_vec++; if (In_Ready !== 4'b0001) begin n_err++; $display("FAIL round%0d_in_ready got %b want 0001", v, In_Ready); end
            step();
            In_Valid = '0;
            n_vec++; if (Out_Valid !== 1'b0) begin n_err++; $display("FAIL round%0d_early_valid got %0b want 0", v, Out_Valid); end
            step();
            n_vec++; if (Out_Valid !== 1'b1) begin n_err++; $display("FAIL round%0d_valid got %0b want 1", v, Out_Valid); end
            n_vec++; if (Out_Data !== ve[v]) begin n_err++; $display("FAIL round%0d_data got %h want %h", v, Out_Data, ve[v]); end
            n_vec++; if (Out_Tag !== 2'd0) begin n_err++; $display("FAIL round%0d_tag got %0d want 0", v, Out_Tag); end
            n_vec++; if (Out_Saturated !== 1'b0) begin n_err++; $display("FAIL round%0d_sat got %0b want 0", v, Out_Saturated); end
            step();
        end
    endtask

    task automatic test_saturation();
        logic [7:0] vi [3] = '{8'h7F, 8'h7F, 8'h80};
        logic [7:0] vf [3] = '{8'h80, 8'hFF, 8'h00};
        logic [7:0] ve [3] = '{8'h7F, 8'h7F, 8'h80};
        logic       vs [3] = '{1'b1, 1'b1, 1'b0};
        Out_Ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            set_ch(2, vi[v], vf[v]);
            In_Valid = 4'b0100;
            #1;
            n_vec++; if (In_Ready !== 4'b0100) begin n_err++; $display("FAIL sat%0d_in_ready got %b want 0100", v, In_Ready); end
            step();
            In_Valid = '0;
            step();
            n_vec++; if (Out_Valid !== 1'b1) begin n_err++; $display("FAIL sat%0d_valid got %0b want 1", v, Out_Valid); end
            n_vec++; if (Out_Data !== ve[v]) begin n_err++; $display("FAIL sat%0d_data got %h want %h", v, Out_Data, ve[v]); end
            n_vec++; if (Out_Tag !== 2'd2) begin n_err++; $display("FAIL sat%0d_tag got %0d want 2", v, Out_Tag); end
            n_vec++; if (Out_Saturated !== vs[v]) begin n_err++; $display("FAIL sat%0d_flag got %0b want %0b", v, Out_Saturated, vs[v]); end
            step();
        end
    endtask

    task automatic load_stream_data();
        for (int k = 0; k < NC; k++) set_ch(k, 8'(8'h10 + k), 8'h00);
    endtask

    task automatic test_fairness();
        int seq [14] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3, 0, 2, 3};
        logic [NC-1:0] exp_rdy;
        pulse_reset();
        load_stream_data();
        Out_Ready = 1'b1;
        for (int j = 0; j < 14; j++) begin
            In_Valid = (j < 8) ? 4'b1111 : 4'b1101;
            #1;
            exp_rdy = 4'b0001 << seq[j];
            n_vec++; if (In_Ready !== exp_rdy) begin n_err++; $display("FAIL fair%0d_in_ready got %b want %b", j, In_Ready, exp_rdy); end
            step();
            if (j >= 1) begin
                n_vec++; if (Out_Valid !== 1'b1) begin n_err++; $display("FAIL fair%0d_valid got %0b want 1", j, Out_Valid); end
                n_vec++; if (Out_Tag !== 2'(seq[j-1])) begin n_err++; $display("FAIL fair%0d_tag got %0d want %0d", j, Out_Tag, seq[j-1]); end
                n_vec++; if (Out_Data !== 8'(8'h10 + seq[j-1])) begin n_err++; $display("FAIL fair%0d_data got %h want %h", j, Out_Data, 8'(8'h10 + seq[j-1])); end
            end
        end
        In_Valid = '0;
        step();
        n_vec++; if (Out_Tag !== 2'd3 || Out_Valid !== 1'b1) begin n_err++; $display("FAIL fair_last got tag %0d valid %0b want 3/1", Out_Tag, Out_Valid); end
        step();
        n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL fair_drain_busy got %0b want 0", Busy); end
    endtask

    task automatic test_backpressure();
        int rel_grant [4] = '{2, 3, 0, 1};
        logic [NC-1:0] exp_rdy;
        pulse_reset();
        load_stream_data();
        Out_Ready = 1'b1;
        In_Valid  = 4'b1111;
        step();
        step();
        // Out holds ch0, stage 1 holds ch1
        Out_Ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            #1;
            n_vec++; if (In_Ready !== 4'b0000) begin n_err++; $display("FAIL bp%0d_in_ready got %b want 0000", j, In_Ready); end
            step();
            n_vec++; if (Out_Valid !== 1'b1 || Out_Tag !== 2'd0 || Out_Data !== 8'h10)
                begin n_err++; $display("FAIL bp%0d_hold got v%0b tag %0d data %h want 1/0/10", j, Out_Valid, Out_Tag, Out_Data); end
        end
        Out_Ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            exp_rdy = 4'b0001 << rel_grant[j];
            n_vec++; if (In_Ready !== exp_rdy) begin n_err++; $display("FAIL bp_rel%0d_in_ready got %b want %b", j, In_Ready, exp_rdy); end
            step();
            // first release edge drains ch0 and moves ch1 out
            n_vec++; if (Out_Valid !== 1'b1 || Out_Tag !== 2'((j + 1) % 4) || Out_Data !== 8'(8'h10 + (j + 1) % 4))
                begin n_err++; $display("FAIL bp_rel%0d_out got v%0b tag %0d data %h want tag %0d", j, Out_Valid, Out_Tag, Out_Data, (j + 1) % 4); end
        end
        In_Valid = '0;
        step();
        n_vec++; if (Out_Tag !== 2'd1 || Out_Valid !== 1'b1) begin n_err++; $display("FAIL bp_tail got tag %0d valid %0b want 1/1", Out_Tag, Out_Valid); end
        step();
        n_vec++; if (Out_Valid !== 1'b0 || Busy !== 1'b0) begin n_err++; $display("FAIL bp_drain got v%0b busy %0b want 0/0", Out_Valid, Busy); end
    endtask

    task automatic test_reset_midstream();
        pulse_reset();
        load_stream_data();
        Out_Ready = 1'b1;
        In_Valid  = 4'b1111;
        step();
        step();
        n_vec++; if (Out_Valid !== 1'b1 || Busy !== 1'b1) begin n_err++; $display("FAIL mid_full got v%0b busy %0b want 1/1", Out_Valid, Busy); end
        In_Valid = '0;
        Reset    = 1'b1;
        step();
        Reset = 1'b0;
        #1;
        n_vec++; if (Out_Valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid got %0b want 0", Out_Valid); end
        n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %0b want 0", Busy); end
        n_vec++; if (In_Ready !== 4'b0000) begin n_err++; $display("FAIL mid_in_ready got %b want 0000", In_Ready); end
        In_Valid = 4'b1111;
        #1;
        n_vec++; if (In_Ready !== 4'b0001) begin n_err++; $display("FAIL mid_regrant got %b want 0001", In_Ready); end
        step();
        In_Valid = '0;
        n_vec++; if (Out_Valid !== 1'b0) begin n_err++; $display("FAIL mid_no_stale got %0b want 0", Out_Valid); end
        step();
        n_vec++; if (Out_Tag !== 2'd0 || Out_Valid !== 1'b1) begin n_err++; $display("FAIL mid_first got tag %0d v%0b want 0/1", Out_Tag, Out_Valid); end
        step();
    endtask

    task automatic test_idle_sparse();
        Out_Ready = 1'b1;
        In_Valid  = '0;
        step();
        set_ch(3, 8'h21, 8'h40);
        In_Valid = 4'b1000;
        #1;
        n_vec++; if (In_Ready !== 4'b1000) begin n_err++; $display("FAIL idle_in_ready got %b want 1000", In_Ready); end
        n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL idle_busy_pre got %0b want 0", Busy); end
        step();
        In_Valid = '0;
        n_vec++; if (Busy !== 1'b1 || Out_Valid !== 1'b0) begin n_err++; $display("FAIL idle_s1 got busy %0b v%0b want 1/0", Busy, Out_Valid); end
        step();
        n_vec++; if (Busy !== 1'b1 || Out_Valid !== 1'b1) begin n_err++; $display("FAIL idle_s2 got busy %0b v%0b want 1/1", Busy, Out_Valid); end
        n_vec++; if (Out_Tag !== 2'd3 || Out_Data !== 8'h21) begin n_err++; $display("FAIL idle_out got tag %0d data %h want 3/21", Out_Tag, Out_Data); end
        step();
        n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL idle_busy_post got %0b want 0", Busy); end
        // pointer wrapped to 0: channel 0 must beat channel 1
        In_Valid = 4'b0011;
        #1;
        n_vec++; if (In_Ready !== 4'b0001) begin n_err++; $display("FAIL idle_ptr_wrap got %b want 0001", In_Ready); end
        step();
        In_Valid = '0;
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_fairness();
        test_backpressure();
        test_reset_midstream();
        test_idle_sparse();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
